access_requester: RTL

- Initiator side of the request/confirm/password access protocol served by the lock FSM.
- Accepts one access command (target code `d` plus password) from local logic.
- Drives the `request`/`confirm`/`password`/`d` sequence, watches the responder's `evenEnable`/`oddEnable` grant lines, and holds the session for a fixed time.
- Retries on timeout and reports granted, denied or error status to the local command source.

---
 rtl/access_requester.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/access_requester.sv
// Initiator side of the request/confirm/password access protocol.
// Runs one command at a time, retries on timeout, and reports granted/denied/error.
module access_requester #(
    parameter int TIMEOUT     = 8,
    parameter int MAX_RETRY   = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int RW          = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    cmd_d,
    input  logic [3:0]    cmd_password,
    input  logic          even_enable_i,
    input  logic          odd_enable_i,
    output logic          request,
    output logic          confirm,
    output logic [3:0]    password,
    output logic [3:0]    d,
    output logic          busy,
    output logic          done,
    output logic          granted,
    output logic          denied,
    output logic          proto_err,
    output logic [RW-1:0] retries_used
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CONF,
        S_WAIT,
        S_HOLD,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    state_t        state;
    logic [TW-1:0] timer;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] retries;
    logic          retry;
    logic          exp_grant;
    logic          other_grant;

    // The latched target's low bit picks which grant line counts as a grant.
    assign exp_grant   = d[0] ? odd_enable_i  : even_enable_i;
    assign other_grant = d[0] ? even_enable_i : odd_enable_i;

    // NOTE: every register here is state, so all updates are non-blocking to
    // avoid ordering races between processes sharing the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            request      <= 1'b0;
            confirm      <= 1'b0;
            password     <= '0;
            d            <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            granted      <= 1'b0;
            denied       <= 1'b0;
            proto_err    <= 1'b0;
            retries_used <= '0;
            timer        <= '0;
            hold_cnt     <= '0;
            retries      <= '0;
            retry        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        d         <= cmd_d;
                        password  <= cmd_password;
                        granted   <= 1'b0;
                        denied    <= 1'b0;
                        proto_err <= 1'b0;
                        retries   <= '0;
                        retry     <= 1'b0;
                        busy      <= 1'b1;
                        request   <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    confirm <= 1'b1;
                    state   <= S_CONF;
                end
                S_CONF: begin
                    confirm <= 1'b0;
                    timer   <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (exp_grant) begin
                        granted  <= 1'b1;
                        retry    <= 1'b0;
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end else if (other_grant) begin
                        proto_err <= 1'b1;
                        retry     <= 1'b0;
                        request   <= 1'b0;
                        state     <= S_RELEASE;
                    end else if (timer == TIMER_LAST) begin
                        request <= 1'b0;
                        state   <= S_RELEASE;
                        if (retries < RETRY_MAX) begin
                            retries <= retries + RW'(1);
                            retry   <= 1'b1;
                        end else begin
                            denied <= 1'b1;
                            retry  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        request <= 1'b0;
                        state   <= S_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RELEASE: begin
                    // One request-low cycle always separates attempts.
                    if (retry) begin
                        request <= 1'b1;
                        state   <= S_REQ;
                    end else begin
                        done         <= 1'b1;
                        retries_used <= retries;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
